// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide sequencer.
// Holds the command op codes, the FSM state encoding and the default data
// width / command latency.
package mdu_pkg;

  localparam int MDU_WIDTH   = 32;
  localparam int MDU_LATENCY = MDU_WIDTH + 1;

  localparam logic [2:0] MDU_NOP   = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: command/result bundle between the execute stage and the
// multiply/divide sequencer. The master issues commands; the slave (the
// sequencer) returns busy and the HI/LO registers.
interface mdu_ctrl_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
);
  logic             start;
  logic [2:0]       mdu_op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, mdu_op, rs_data, rt_data,
    input  busy, hi, lo
  );

  modport slave (
    input  start, mdu_op, rs_data, rt_data,
    output busy, hi, lo
  );
endinterface

// File: rtl/mdu_step.sv
// mdu_step: one combinational iteration of the multiply/divide loop.
// Multiply: acc = {partial high, remaining multiplier}; add opd when the
// multiplier LSB is set, then shift right one place.
// Divide (only when MDU_DIV_EN is defined): acc = {remainder, dividend/quotient};
// shift left, trial-subtract opd from the widened remainder and shift in the
// quotient bit (restoring division).
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opd,
  input  logic               sub_mode,
  output logic [2*WIDTH-1:0] acc_nxt
);
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   add_nxt;
`ifdef MDU_DIV_EN
  logic [WIDTH:0]       rem_sh;
  logic                 qbit;
  logic [WIDTH-1:0]     new_rem;
  logic [2*WIDTH-1:0]   sub_nxt;
`endif

  // Single add-shift or subtract-shift step selected by sub_mode
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opd : {WIDTH{1'b0}})};
    add_nxt = {sum, acc[WIDTH-1:1]};
`ifdef MDU_DIV_EN
    rem_sh  = acc[2*WIDTH-1:WIDTH-1];
    qbit    = (rem_sh >= {1'b0, opd});
    new_rem = qbit ? WIDTH'(rem_sh - {1'b0, opd}) : rem_sh[WIDTH-1:0];
    sub_nxt = {new_rem, acc[WIDTH-2:0], qbit};
    acc_nxt = sub_mode ? sub_nxt : add_nxt;
`else
    acc_nxt = sub_mode ? acc : add_nxt;
`endif
  end
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative multiply/divide sequencer owning HI/LO.
// Runs a WIDTH-cycle shift-add multiply or restoring divide on operand
// magnitudes, then one FIX cycle applies the sign correction.
// Optional feature macro: MDU_DIV_EN (DIV/DIVU support; undefined => DIV/DIVU act as NOP).
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic      clk,
  input  logic      reset,
  mdu_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  mdu_state_t         state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt, prod;
  logic [WIDTH-1:0]   opd, rs_mag, rt_mag, hi_r, lo_r;
  logic               neg_q, neg_r, divz, div_op;
  logic               accept, is_mul, is_div, is_sgn, sub_mode;

  // Magnitude of a possibly-signed operand; the most negative value maps to itself.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v, input logic sgn);
    return (sgn && (v < 0)) ? $unsigned(-v) : $unsigned(v);
  endfunction

  // Two's-complement sign correction of a magnitude result.
  function automatic logic [WIDTH-1:0] fix_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign accept = (state == IDLE) && bus.start;
  assign is_mul = (bus.mdu_op == MDU_MULT) || (bus.mdu_op == MDU_MULTU);
  assign is_sgn = (bus.mdu_op == MDU_MULT) || (bus.mdu_op == MDU_DIV);
`ifdef MDU_DIV_EN
  assign is_div   = (bus.mdu_op == MDU_DIV) || (bus.mdu_op == MDU_DIVU);
  assign sub_mode = (state == DIV);
`else
  assign is_div   = 1'b0;
  assign sub_mode = 1'b0;
`endif
  assign rs_mag = mag(bus.rs_data, is_sgn);
  assign rt_mag = mag(bus.rt_data, is_sgn);
  assign prod   = neg_q ? -acc : acc;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .opd      (opd),
    .sub_mode (sub_mode),
    .acc_nxt  (acc_nxt)
  );

  // FSM state register and iteration counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept && (is_mul || is_div))
        cnt <= CW'(WIDTH - 1);
      else if (((state == MUL) || (state == DIV)) && (cnt != '0))
        cnt <= cnt - CW'(1);
    end
  end

  // Next-state decode; MTHI/MTLO and NOP stay in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_mul)      state_nxt = MUL;
          else if (is_div) state_nxt = DIV;
        end
      end
      MUL: if (cnt == '0) state_nxt = FIX;
`ifdef MDU_DIV_EN
      DIV: if (cnt == '0) state_nxt = FIX;
`endif
      FIX: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch at command accept, then one iteration per MUL/DIV cycle
  always_ff @(posedge clk) begin
    if (accept && (is_mul || is_div)) begin
      acc    <= {{WIDTH{1'b0}}, (is_mul ? rt_mag : rs_mag)};
      opd    <= is_mul ? rs_mag : rt_mag;
      neg_q  <= is_sgn && (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
      neg_r  <= is_sgn && bus.rs_data[WIDTH-1];
      divz   <= (bus.rt_data == '0);
      div_op <= is_div;
    end else if ((state == MUL) || (state == DIV)) begin
      acc <= acc_nxt;
    end
  end

  // HI/LO: written in FIX or by MTHI/MTLO from IDLE, held otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (state == FIX) begin
      if (div_op) begin
        hi_r <= fix_w(acc[2*WIDTH-1:WIDTH], neg_r);
        lo_r <= divz ? {WIDTH{1'b1}} : fix_w(acc[WIDTH-1:0], neg_q);
      end else begin
        hi_r <= prod[2*WIDTH-1:WIDTH];
        lo_r <= prod[WIDTH-1:0];
      end
    end else if (accept && (bus.mdu_op == MDU_MTHI)) begin
      hi_r <= bus.rs_data;
    end else if (accept && (bus.mdu_op == MDU_MTLO)) begin
      lo_r <= bus.rs_data;
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl.
// Covers both builds: DIV/DIVU vectors when MDU_DIV_EN is defined, NOP
// behaviour of DIV/DIVU otherwise.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n;

  mdu_ctrl_if #(.WIDTH(W)) bus ();

  mdu_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt);
    bus.start   = 1'b1;
    bus.mdu_op  = op;
    bus.rs_data = rs;
    bus.rt_data = rt;
    tick();
    bus.start   = 1'b0;
  endtask

  // Issue a command and count the cycles busy stays high (bounded).
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt,
                        output int cyc);
    issue(op, rs, rt);
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.mdu_op  = MDU_NOP;
    bus.rs_data = '0;
    bus.rt_data = '0;
    reset       = 1'b1;
    tick();
    tick();
    chk("rst_busy", W'(bus.busy), 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    reset = 1'b0;

    issue(MDU_MTHI, 32'h0000_1234, 32'h0);
    chk("mthi_hi", bus.hi, 32'h0000_1234);
    chk("mthi_busy", W'(bus.busy), 0);
    issue(MDU_MTLO, 32'h0000_5678, 32'h0);
    chk("mtlo_lo", bus.lo, 32'h0000_5678);
    chk("mtlo_hi", bus.hi, 32'h0000_1234);

    run_op(3'd7, 32'h1, 32'h1, n);
    chk("rsv_busy", W'(n), 0);
    chk("rsv_hi", bus.hi, 32'h0000_1234);
    chk("rsv_lo", bus.lo, 32'h0000_5678);

    run_op(MDU_MULTU, 32'hFFFF_0000, 32'd16, n);
    chk("multu_cyc", W'(n), W'(MDU_LATENCY));
    chk("multu_hi", bus.hi, 32'h0000_000F);
    chk("multu_lo", bus.lo, 32'hFFF0_0000);

    run_op(MDU_MULT, 32'hFFFF_FFFD, 32'd7, n);
    chk("mult_neg_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo", bus.lo, 32'hFFFF_FFEB);

    run_op(MDU_MULT, 32'h8000_0000, 32'd2, n);
    chk("mult_min_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_min_lo", bus.lo, 32'h0000_0000);

    run_op(MDU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    chk("mult_nn_hi", bus.hi, 32'h0);
    chk("mult_nn_lo", bus.lo, 32'h1);

`ifdef MDU_DIV_EN
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, n);
    chk("div_cyc", W'(n), W'(MDU_LATENCY));
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);

    run_op(MDU_DIVU, 32'd100, 32'd0, n);
    chk("divz_cyc", W'(n), W'(MDU_LATENCY));
    chk("divz_lo", bus.lo, 32'hFFFF_FFFF);
    chk("divz_hi", bus.hi, 32'd100);

    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
    chk("divovf_lo", bus.lo, 32'h8000_0000);
    chk("divovf_hi", bus.hi, 32'h0);

    run_op(MDU_DIVU, 32'd1000, 32'd7, n);
    chk("divu_lo", bus.lo, 32'd142);
    chk("divu_hi", bus.hi, 32'd6);
`else
    run_op(MDU_DIV, 32'd9, 32'd3, n);
    chk("divoff_busy", W'(n), 0);
    chk("divoff_hi", bus.hi, 32'h0);
    chk("divoff_lo", bus.lo, 32'h1);
    run_op(MDU_DIVU, 32'd9, 32'd3, n);
    chk("divuoff_busy", W'(n), 0);
    chk("divuoff_lo", bus.lo, 32'h1);
    run_op(MDU_MULT, 32'hFFFF_FFFD, 32'd7, n);
    chk("divoff_mult_lo", bus.lo, 32'hFFFF_FFEB);
`endif

    // MTHI presented while busy must be dropped
    issue(MDU_MTHI, 32'h0000_AAAA, 32'h0);
    issue(MDU_MULTU, 32'd5, 32'd6);
    n = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      n++;
    end
    issue(MDU_MTHI, 32'h0000_1234, 32'h0);
    n++;
    chk("ign_busy", W'(bus.busy), 1);
    chk("ign_hold_hi", bus.hi, 32'h0000_AAAA);
    while (bus.busy && n < 200) begin
      tick();
      n++;
    end
    chk("ign_cyc", W'(n), W'(MDU_LATENCY));
    chk("ign_hi", bus.hi, 32'h0);
    chk("ign_lo", bus.lo, 32'd30);

    // Reset in the middle of an iteration
    issue(MDU_MTHI, 32'h0000_BEEF, 32'h0);
`ifdef MDU_DIV_EN
    issue(MDU_DIV, 32'd1000, 32'd7);
`else
    issue(MDU_MULTU, 32'd1000, 32'd7);
`endif
    for (int i = 0; i < 14; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_busy", W'(bus.busy), 0);
    chk("mrst_hi", bus.hi, 32'h0);
    chk("mrst_lo", bus.lo, 32'h0);
    tick();
    chk("mrst_stay", W'(bus.busy), 0);

    run_op(MDU_MULTU, 32'd2, 32'd3, n);
    chk("post_cyc", W'(n), W'(MDU_LATENCY));
    chk("post_lo", bus.lo, 32'd6);
    chk("post_hi", bus.hi, 32'd0);

    // Reset and start on the same edge: reset wins
    issue(MDU_MTLO, 32'h0000_0077, 32'h0);
    chk("pre_lo", bus.lo, 32'h0000_0077);
    reset = 1'b1;
    issue(MDU_MULTU, 32'd3, 32'd3);
    chk("rs_busy", W'(bus.busy), 0);
    chk("rs_lo", bus.lo, 32'h0);
    issue(MDU_MTHI, 32'h0000_0055, 32'h0);
    chk("rs_mthi", bus.hi, 32'h0);
    reset = 1'b0;
    tick();
    chk("rs_after", W'(bus.busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
